// File: rtl/smpl_capture.sv
// Capture controller: writes strobed samples into a circular RAM, enforces a
// pre-trigger fill, waits for a trigger, keeps trig_pos post-trigger samples.
module smpl_capture #(
    parameter int unsigned ENTRIES = 384,
    parameter int unsigned ADDR_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrt_smpl,
    input  logic [7:0]        smpl,
    input  logic              run,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              triggered,
    output logic              armed,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trig_addr
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic              armed_q, armed_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;

    logic [ADDR_W-1:0] tp_c;
    logic [CNT_W-1:0]  pre_n_c;
    logic [CNT_W-1:0]  pre_inc_c;
    logic              wr_c;
    logic              start_c;

    // Saturate the post-trigger count so at least one pre-trigger sample is kept.
    assign tp_c      = (trig_pos > LAST_ADDR) ? LAST_ADDR : trig_pos;
    assign pre_n_c   = CNT_W'(ENTRIES) - CNT_W'(tp_c);
    assign pre_inc_c = pre_cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        armed_d     = armed_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        done_d      = done_q;
        trig_addr_d = trig_addr_q;
        wr_c        = 1'b0;
        start_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) start_c = 1'b1;
            end
            S_PRE: begin
                if (wrt_smpl) begin
                    wr_c      = 1'b1;
                    pre_cnt_d = pre_inc_c;
                    if (pre_inc_c >= pre_n_c) begin
                        state_d = S_ARMED;
                        armed_d = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (wrt_smpl) begin
                    wr_c = 1'b1;
                    if (triggered) begin
                        state_d    = S_POST;
                        post_cnt_d = '0;
                    end
                end
            end
            S_POST: begin
                // Once the post-trigger quota is met no further samples are taken.
                if (post_cnt_q == tp_c) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    armed_d     = 1'b0;
                    trig_addr_d = waddr_q;
                end else if (wrt_smpl) begin
                    wr_c       = 1'b1;
                    post_cnt_d = post_cnt_q + ADDR_W'(1);
                end
            end
            S_DONE: begin
                if (run) start_c = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (start_c) begin
            state_d    = S_PRE;
            wptr_d     = '0;
            pre_cnt_d  = '0;
            post_cnt_d = '0;
            done_d     = 1'b0;
            armed_d    = 1'b0;
        end

        if (wr_c) begin
            we_d    = 1'b1;
            waddr_d = wptr_q;
            wdata_d = smpl;
            wptr_d  = (wptr_q == LAST_ADDR) ? '0 : wptr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            armed_q     <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            trig_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            armed_q     <= armed_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            trig_addr_q <= trig_addr_d;
        end
    end

    assign armed        = armed_q;
    assign we           = we_q;
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;
    assign capture_done = done_q;
    assign trig_addr    = trig_addr_q;

endmodule

// File: tb/tb_smpl_capture.sv
// Directed bench for smpl_capture with an 8-entry buffer and 4-bit addresses.
module tb_smpl_capture;

    localparam int unsigned ENTRIES = 8;
    localparam int unsigned ADDR_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              wrt_smpl;
    logic [7:0]        smpl;
    logic              run;
    logic [ADDR_W-1:0] trig_pos;
    logic              triggered;
    logic              armed;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;
    logic              capture_done;
    logic [ADDR_W-1:0] trig_addr;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int wr_base;
    logic [ADDR_W-1:0] exp_addr;

    smpl_capture #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wrt_smpl     (wrt_smpl),
        .smpl         (smpl),
        .run          (run),
        .trig_pos     (trig_pos),
        .triggered    (triggered),
        .armed        (armed),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .capture_done (capture_done),
        .trig_addr    (trig_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count RAM write pulses independently of the directed checks.
    always @(negedge clk) begin
        if (we === 1'b1) wr_cnt = wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    // One strobe; checks the write one clock later, then idles.
    task automatic do_write(input int n, input logic trig, input int idle, input logic exp_we);
        wrt_smpl  = 1'b1;
        smpl      = 8'(32'h10 + n);
        triggered = trig;
        tick();
        wrt_smpl = 1'b0;
        if (exp_we) begin
            chk("we", 32'(we), 32'd1);
            chk("waddr", 32'(waddr), 32'(exp_addr));
            chk("wdata", 32'(wdata), 32'h10 + n);
            exp_addr = (exp_addr == ADDR_W'(ENTRIES - 1)) ? '0 : exp_addr + ADDR_W'(1);
        end else begin
            chk("we_none", 32'(we), 32'd0);
        end
        repeat (idle) tick();
    endtask

    initial begin
        rst_n = 1'b0; wrt_smpl = 1'b0; smpl = '0; run = 1'b0;
        trig_pos = '0; triggered = 1'b0; exp_addr = '0;
        repeat (2) tick();
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_done", 32'(capture_done), 32'd0);
        chk("rst_trig_addr", 32'(trig_addr), 32'd0);
        rst_n = 1'b1;
        tick();

        // tp=2: fill 6, trigger on sample 9 (addr 1), keep addrs 2,3; run in ARMED ignored
        trig_pos = 4'd2;
        exp_addr = '0;
        pulse_run();
        wr_base = wr_cnt;
        for (int n = 0; n < 12; n++) begin
            do_write(n, (n == 9), 3, 1'b1);
            if (n == 4) chk("t2_armed_pre", 32'(armed), 32'd0);
            if (n == 5) chk("t2_armed_6th", 32'(armed), 32'd1);
            if (n == 6) pulse_run();
            if (n == 10) chk("t2_done_early", 32'(capture_done), 32'd0);
        end
        chk("t2_done", 32'(capture_done), 32'd1);
        chk("t2_trig_addr", 32'(trig_addr), 32'd3);
        chk("t2_armed_off", 32'(armed), 32'd0);
        chk("t2_wr_cnt", 32'(wr_cnt - wr_base), 32'd12);
        do_write(12, 1'b0, 3, 1'b0);

        // Restart from DONE with triggered held high through the pre-trigger fill
        pulse_run();
        chk("t3_done_clr", 32'(capture_done), 32'd0);
        chk("t3_armed_clr", 32'(armed), 32'd0);
        exp_addr = '0;
        wr_base  = wr_cnt;
        for (int n = 0; n < 9; n++) begin
            do_write(n, 1'b1, 3, 1'b1);
            if (n == 4) chk("t3_armed_pre", 32'(armed), 32'd0);
            if (n == 5) chk("t3_armed_6th", 32'(armed), 32'd1);
            if (n == 7) chk("t3_done_early", 32'(capture_done), 32'd0);
        end
        chk("t3_done", 32'(capture_done), 32'd1);
        chk("t3_trig_addr", 32'(trig_addr), 32'd0);
        chk("t3_wr_cnt", 32'(wr_cnt - wr_base), 32'd9);

        // tp=0: trigger at addr 5, done one clock after its write
        trig_pos  = 4'd0;
        triggered = 1'b0;
        pulse_run();
        exp_addr = '0;
        for (int n = 0; n < 13; n++) begin
            do_write(n, 1'b0, 3, 1'b1);
            if (n == 6) chk("t4_armed_pre", 32'(armed), 32'd0);
            if (n == 7) chk("t4_armed_full", 32'(armed), 32'd1);
        end
        do_write(13, 1'b1, 0, 1'b1);
        chk("t4_done_at_wr", 32'(capture_done), 32'd0);
        tick();
        chk("t4_done", 32'(capture_done), 32'd1);
        chk("t4_trig_addr", 32'(trig_addr), 32'd5);
        chk("t4_armed_off", 32'(armed), 32'd0);
        do_write(14, 1'b0, 3, 1'b0);

        // Asynchronous reset mid-capture while a write is in flight
        trig_pos  = 4'd7;
        triggered = 1'b0;
        pulse_run();
        exp_addr = '0;
        do_write(0, 1'b0, 3, 1'b1);
        chk("t1_armed_before", 32'(armed), 32'd1);
        do_write(1, 1'b1, 0, 1'b1);
        wrt_smpl = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_armed", 32'(armed), 32'd0);
        chk("t1_we", 32'(we), 32'd0);
        chk("t1_waddr", 32'(waddr), 32'd0);
        chk("t1_wdata", 32'(wdata), 32'd0);
        chk("t1_done", 32'(capture_done), 32'd0);
        chk("t1_trig_addr", 32'(trig_addr), 32'd0);
        wrt_smpl = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_write(0, 1'b0, 3, 1'b0);

        // trig_pos=9 saturates to 7: armed after one write, 7 post-trigger writes
        trig_pos = 4'd9;
        pulse_run();
        exp_addr = '0;
        wr_base  = wr_cnt;
        do_write(0, 1'b0, 3, 1'b1);
        chk("t6_armed", 32'(armed), 32'd1);
        do_write(1, 1'b1, 3, 1'b1);
        for (int n = 2; n < 9; n++) begin
            do_write(n, 1'b0, 3, 1'b1);
            if (n == 7) chk("t6_done_early", 32'(capture_done), 32'd0);
        end
        chk("t6_done", 32'(capture_done), 32'd1);
        chk("t6_trig_addr", 32'(trig_addr), 32'd0);
        chk("t6_armed_off", 32'(armed), 32'd0);
        chk("t6_wr_cnt", 32'(wr_cnt - wr_base), 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
